tl_inflight_monitor: RTL
========================

// Module: tl_inflight_monitor
// PURPOSE
// - Parametrised TL-UH protocol checker. Observes NUM_PORTS A-channel masters through the arbiter grant (a_sel)
//   and one shared D channel; simulation/formal only.
// - Tracks per-source in-flight state, multi-beat burst consistency, grant stability and response timeout.
// - Raises sticky error flags; replaces the fixed two-way mux-into-monitor wrapper.
// PARAMETERS
// - NUM_PORTS   2   number of A-channel masters (>=1)
// - SRC_W       4   source-ID width; tracks 2**SRC_W IDs
// - SIZE_W      3   a_size/d_size width (log2 bytes)
// - BEAT_BYTES  8   data-bus bytes per beat (power of two)
// - TIMEOUT     256 max cycles with anything in flight and no D fire; 0 disables
// PORTS
// - clock      in   1                     clock
// - reset      in   1                     synchronous, active-high
// - a_valid    in   NUM_PORTS             per-port A valid
// - a_ready    in   NUM_PORTS             per-port A ready
// - a_opcode   in   NUM_PORTS*3           packed, port 0 in LSBs
// - a_size     in   NUM_PORTS*SIZE_W      packed
// - a_source   in   NUM_PORTS*SRC_W       packed
// - a_sel      in   max(1,$clog2(NUM_PORTS))  arbiter grant (index of observed port)
// - d_valid    in   1                     D valid
// - d_ready    in   1                     D ready
// - d_opcode   in   3                     D opcode
// - d_size     in   SIZE_W                D size
// - d_source   in   SRC_W                 D source
// - err_vec    out  7                     sticky error bits, indices in package
// - err_pulse  out  1                     high one cycle whenever any err_vec bit newly sets
// - inflight   out  2**SRC_W              current in-flight bitmap
// BEHAVIOUR
// - Reset: err_vec=0, err_pulse=0, inflight=0, both beat counters idle, timeout counter 0. Reset mid-burst aborts silently.
// - a_fire = a_valid[a_sel] & a_ready[a_sel]; d_fire = d_valid & d_ready. a_sel >= NUM_PORTS: nothing observed.
// - Beats:
//   - A: opcodes 0..3 (Put/Arith/Logic): max(1, 2**size/BEAT_BYTES); else 1.
//   - D: AccessAckData(1): max(1, 2**size/BEAT_BYTES); else 1.
// - Beat counter idle -> first beat loads beats-1 and latches opcode/size/source (plus a_sel for A).
//   Each later fire decrements; reaching 0 = last beat, back to idle. Single-beat: first==last, no busy state.
// - inflight:
//   - Bit set on A first beat. Bit cleared on D last beat.
//   - D clear is applied before the A check in the same cycle, so reusing a source in the cycle its D completes is legal.
// - err bits (set in cycle after event, never cleared except by reset):
//   - 0 A_SRC_BUSY: A first beat to a set bit.
//   - 1 D_SRC_IDLE: D first beat to a clear bit (checked against pre-cycle state).
//   - 2 A_BURST_CHG: A opcode/size/source differs from latched value on a non-first beat.
//   - 3 D_BURST_CHG: same check for D.
//   - 4 TIMEOUT: counter == TIMEOUT. Counter increments while inflight!=0 and !d_fire; clears on d_fire or inflight==0.
//     It saturates and does not re-fire the pulse.
//   - 5 SEL_MIDBURST: a_sel differs from latched sel while A burst is busy.
//   - 6 A_ILLEGAL_OP: a_fire with opcode 6 or 7.
// - err_pulse = |(next_err & ~err_vec) registered. Multiple errors in one cycle set together; one pulse.
// - No back-pressure; all outputs registered; detection latency 1 cycle.
// STRUCTURE
// - Package tl_mon_pkg: A/D opcode enums, ERR_* index localparams, ERR_W=7, function beats(opcode, size, is_d).
// - Sub-module tl_beat_counter (parameters SIZE_W, SRC_W, BEAT_BYTES, IS_D).
//   - Instantiated once for A, once for D.
//   - Outputs first, last, busy, mismatch.
// - Top contains the port mux, inflight bitmap, timeout counter and error register.
// TESTING
// - NUM_PORTS=2, port1 Get src 3, then AccessAckData size 3 src 3 -> inflight[3] 1 then 0; err_vec=0.
// - Two Gets src 5 back-to-back, no D between -> err_vec[0]=1, one err_pulse; D src 9 when idle -> err_vec[1]=1.
// - PutFullData size 5 (4 beats), source changes on beat 3 -> err_vec[2]=1; a_sel flips beat 2 -> err_vec[5]=1.
// - TIMEOUT=16: Get src 0, withhold D -> err_vec[4] set exactly 16 cycles after the A fire; single pulse.
// - A first beat src 2 and D last beat src 2 in the same cycle -> no error, inflight[2] stays 1.
// - Reset asserted mid 4-beat Put -> all state 0; a fresh single-beat Get afterwards raises no error.

Source files
------------

// File: rtl/tl_mon_pkg.sv
// Shared TileLink-UH monitor definitions: opcodes, error-bit indices and the beat-count helper.
package tl_mon_pkg;

    typedef enum logic [2:0] {
        A_PUT_FULL    = 3'd0,
        A_PUT_PARTIAL = 3'd1,
        A_ARITHMETIC  = 3'd2,
        A_LOGICAL     = 3'd3,
        A_GET         = 3'd4,
        A_INTENT      = 3'd5
    } a_opcode_e;

    typedef enum logic [2:0] {
        D_ACCESS_ACK      = 3'd0,
        D_ACCESS_ACK_DATA = 3'd1,
        D_HINT_ACK        = 3'd2
    } d_opcode_e;

    localparam int unsigned ERR_A_SRC_BUSY   = 0;
    localparam int unsigned ERR_D_SRC_IDLE   = 1;
    localparam int unsigned ERR_A_BURST_CHG  = 2;
    localparam int unsigned ERR_D_BURST_CHG  = 3;
    localparam int unsigned ERR_TIMEOUT      = 4;
    localparam int unsigned ERR_SEL_MIDBURST = 5;
    localparam int unsigned ERR_A_ILLEGAL_OP = 6;
    localparam int unsigned ERR_W            = 7;

    // Number of data beats a message occupies; only data-carrying opcodes span several beats.
    function automatic int unsigned beats(input logic [2:0] opcode, input int unsigned size,
                                          input logic is_d, input int unsigned beat_bytes);
        logic        multi;
        int unsigned bytes;
        multi = is_d ? (opcode == D_ACCESS_ACK_DATA) : (opcode <= A_LOGICAL);
        bytes = 32'd1 << size;
        if (!multi || bytes <= beat_bytes) begin
            return 32'd1;
        end
        return bytes / beat_bytes;
    endfunction

endpackage

// File: rtl/tl_inflight_monitor_beat_counter.sv
// Per-channel burst tracker: counts remaining beats and flags header changes inside a burst.
module tl_beat_counter
    import tl_mon_pkg::*;
#(
    parameter int unsigned SIZE_W     = 3,
    parameter int unsigned SRC_W      = 4,
    parameter int unsigned BEAT_BYTES = 8,
    parameter bit          IS_D       = 1'b0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              fire,
    input  logic [2:0]        opcode,
    input  logic [SIZE_W-1:0] size,
    input  logic [SRC_W-1:0]  source,
    output logic              first,
    output logic              last,
    output logic              busy,
    output logic              mismatch
);

    // Widest burst is 2**(2**SIZE_W - 1) bytes, so beats-1 always fits here.
    localparam int unsigned CNT_W = (32'd1 << SIZE_W) - 32'd1;

    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  load_c;
    logic [2:0]        op_q;
    logic [SIZE_W-1:0] size_q;
    logic [SRC_W-1:0]  src_q;

    always_comb begin
        load_c   = CNT_W'(beats(opcode, 32'(size), IS_D, BEAT_BYTES) - 32'd1);
        busy     = (cnt != '0);
        first    = fire & ~busy;
        last     = fire & (busy ? (cnt == CNT_W'(1)) : (load_c == '0));
        mismatch = fire & busy & ((opcode != op_q) | (size != size_q) | (source != src_q));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt    <= '0;
            op_q   <= '0;
            size_q <= '0;
            src_q  <= '0;
        end else if (first) begin
            cnt    <= load_c;
            op_q   <= opcode;
            size_q <= size;
            src_q  <= source;
        end else if (fire) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/tl_inflight_monitor.sv
// TL-UH protocol checker: observes the granted A port and the shared D channel, raises sticky errors.
module tl_inflight_monitor
    import tl_mon_pkg::*;
#(
    parameter int unsigned NUM_PORTS  = 2,
    parameter int unsigned SRC_W      = 4,
    parameter int unsigned SIZE_W     = 3,
    parameter int unsigned BEAT_BYTES = 8,
    parameter int unsigned TIMEOUT    = 256,
    localparam int unsigned SEL_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
    localparam int unsigned NSRC      = 32'd1 << SRC_W
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_PORTS-1:0]        a_valid,
    input  logic [NUM_PORTS-1:0]        a_ready,
    input  logic [NUM_PORTS*3-1:0]      a_opcode,
    input  logic [NUM_PORTS*SIZE_W-1:0] a_size,
    input  logic [NUM_PORTS*SRC_W-1:0]  a_source,
    input  logic [SEL_W-1:0]            a_sel,
    input  logic                        d_valid,
    input  logic                        d_ready,
    input  logic [2:0]                  d_opcode,
    input  logic [SIZE_W-1:0]           d_size,
    input  logic [SRC_W-1:0]            d_source,
    output logic [ERR_W-1:0]            err_vec,
    output logic                        err_pulse,
    output logic [NSRC-1:0]             inflight
);

    localparam int unsigned TO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic              a_fire;
    logic [2:0]        a_op;
    logic [SIZE_W-1:0] a_sz;
    logic [SRC_W-1:0]  a_src;
    logic              d_fire;

    logic a_first, a_last, a_busy, a_mismatch;
    logic d_first, d_last, d_busy, d_mismatch;
    logic unused_beats;

    logic [SEL_W-1:0] sel_q;
    logic [TO_W-1:0]  to_cnt;
    logic [TO_W-1:0]  to_nxt;
    logic [NSRC-1:0]  inflight_mid;
    logic [NSRC-1:0]  inflight_nxt;
    logic [ERR_W-1:0] err_new;

    // Grant mux: an out-of-range a_sel observes nothing.
    always_comb begin
        a_fire = 1'b0;
        a_op   = '0;
        a_sz   = '0;
        a_src  = '0;
        if (32'(a_sel) < NUM_PORTS) begin
            a_fire = a_valid[a_sel] & a_ready[a_sel];
            a_op   = a_opcode[32'(a_sel) * 3 +: 3];
            a_sz   = a_size[32'(a_sel) * SIZE_W +: SIZE_W];
            a_src  = a_source[32'(a_sel) * SRC_W +: SRC_W];
        end
        d_fire = d_valid & d_ready;
    end

    tl_beat_counter #(
        .SIZE_W     (SIZE_W),
        .SRC_W      (SRC_W),
        .BEAT_BYTES (BEAT_BYTES),
        .IS_D       (1'b0)
    ) u_a_cnt (
        .clock    (clock),
        .reset    (reset),
        .fire     (a_fire),
        .opcode   (a_op),
        .size     (a_sz),
        .source   (a_src),
        .first    (a_first),
        .last     (a_last),
        .busy     (a_busy),
        .mismatch (a_mismatch)
    );

    tl_beat_counter #(
        .SIZE_W     (SIZE_W),
        .SRC_W      (SRC_W),
        .BEAT_BYTES (BEAT_BYTES),
        .IS_D       (1'b1)
    ) u_d_cnt (
        .clock    (clock),
        .reset    (reset),
        .fire     (d_fire),
        .opcode   (d_opcode),
        .size     (d_size),
        .source   (d_source),
        .first    (d_first),
        .last     (d_last),
        .busy     (d_busy),
        .mismatch (d_mismatch)
    );

    assign unused_beats = a_last ^ d_busy;

    // D completion frees its source before the A check, so same-cycle reuse is legal.
    always_comb begin
        inflight_mid = inflight & ~(d_last ? (NSRC'(1) << d_source) : '0);
        inflight_nxt = inflight_mid | (a_first ? (NSRC'(1) << a_src) : '0);

        to_nxt = '0;
        if (TIMEOUT != 0 && inflight != '0 && !d_fire) begin
            to_nxt = (to_cnt == TO_W'(TIMEOUT)) ? to_cnt : to_cnt + TO_W'(1);
        end

        err_new                   = '0;
        err_new[ERR_A_SRC_BUSY]   = a_first & inflight_mid[a_src];
        err_new[ERR_D_SRC_IDLE]   = d_first & ~inflight[d_source];
        err_new[ERR_A_BURST_CHG]  = a_mismatch;
        err_new[ERR_D_BURST_CHG]  = d_mismatch;
        err_new[ERR_TIMEOUT]      = (TIMEOUT != 0) && (to_nxt == TO_W'(TIMEOUT));
        err_new[ERR_SEL_MIDBURST] = a_busy & (a_sel != sel_q);
        err_new[ERR_A_ILLEGAL_OP] = a_fire & (a_op >= 3'd6);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            inflight  <= '0;
            err_vec   <= '0;
            err_pulse <= 1'b0;
            to_cnt    <= '0;
            sel_q     <= '0;
        end else begin
            inflight  <= inflight_nxt;
            err_vec   <= err_vec | err_new;
            err_pulse <= |(err_new & ~err_vec);
            to_cnt    <= to_nxt;
            if (a_first) begin
                sel_q <= a_sel;
            end
        end
    end

endmodule
